// File: rtl/board_level_frame_buffer_pkg.sv
// board_level_frame_buffer_pkg: write-FSM states and RAM entry width shared by the frame buffer.
package board_level_frame_buffer_pkg;
    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;
    localparam int ENTRY_W = 9;
endpackage

// File: rtl/board_level_frame_buffer_ram.sv
// board_level_frame_buffer_ram: simple dual-port RAM of {last, data} entries, one write port, synchronous read.
module board_level_frame_buffer_ram
    import board_level_frame_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_we,
    input  logic [ADDR_WIDTH-1:0] i_waddr,
    input  logic [ENTRY_W-1:0]    i_wdata,
    input  logic                  i_re,
    input  logic [ADDR_WIDTH-1:0] i_raddr,
    output logic [ENTRY_W-1:0]    o_rdata
);
    logic [ENTRY_W-1:0] r_mem [2**ADDR_WIDTH];
    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end
    // The read register doubles as the show-ahead output stage, so it only moves on a fetch.
    always_ff @(posedge clk) begin
        if (rst) o_rdata <= '0;
        else if (i_re) o_rdata <= r_mem[i_raddr];
    end
endmodule

// File: rtl/board_level_frame_buffer.sv
// board_level_frame_buffer: stores received frames in a RAM ring and releases only CRC-clean ones as a valid/ready stream.
// Define FRAME_STATS_EN to add saturating stat_good/stat_crc/stat_ovf counters.
module board_level_frame_buffer
    import board_level_frame_buffer_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_frame_start,
    input  logic       in_frame_end,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_error,
    output logic [7:0] out_data,
    output logic       out_last,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       drop_crc,
    output logic       drop_ovf
`ifdef FRAME_STATS_EN
    ,
    output logic [15:0] stat_good,
    output logic [15:0] stat_crc,
    output logic [15:0] stat_ovf
`endif
);
    localparam logic [ADDR_WIDTH:0] DEPTH = {1'b1, {ADDR_WIDTH{1'b0}}};
    state_t              r_state;
    logic [ADDR_WIDTH:0] r_wr_ptr, r_commit_ptr, r_rd_ptr;
    logic                r_stg_valid;
    logic [7:0]          r_stg_data;
    logic                w_start, w_end, w_data, w_full, w_we, w_commit, w_load;
    logic [ADDR_WIDTH:0] w_used;
    assign w_start  = in_valid & in_frame_start;
    assign w_end    = in_valid & in_frame_end & ~in_frame_start;
    assign w_data   = in_valid & ~in_frame_start & ~in_frame_end;
    assign w_used   = r_wr_ptr - r_rd_ptr;
    assign w_full   = w_used == DEPTH;
    // A staged byte is written when the next event reveals whether it is the last one.
    assign w_we     = (r_state == RECV) & r_stg_valid & ~w_full & (w_data | (w_end & ~in_error));
    assign w_commit = (r_state == RECV) & w_end & r_stg_valid & ~in_error & ~w_full;
    assign w_load   = (r_commit_ptr != r_rd_ptr) & (~out_valid | out_ready);

    board_level_frame_buffer_ram #(.ADDR_WIDTH(ADDR_WIDTH)) u_ram (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_we),
        .i_waddr (r_wr_ptr[ADDR_WIDTH-1:0]),
        .i_wdata ({w_end, r_stg_data}),
        .i_re    (w_load),
        .i_raddr (r_rd_ptr[ADDR_WIDTH-1:0]),
        .o_rdata ({out_last, out_data})
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_wr_ptr     <= '0;
            r_commit_ptr <= '0;
            r_stg_valid  <= 1'b0;
            r_stg_data   <= '0;
            drop_crc     <= 1'b0;
            drop_ovf     <= 1'b0;
        end else begin
            drop_crc <= 1'b0;
            drop_ovf <= 1'b0;
            if (w_we) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_commit) r_commit_ptr <= r_wr_ptr + 1'b1;
            case (r_state)
                IDLE: if (w_start) begin
                    r_state     <= RECV;
                    r_wr_ptr    <= r_commit_ptr;
                    r_stg_valid <= 1'b0;
                end
                RECV: if (w_start) begin
                    r_wr_ptr    <= r_commit_ptr;
                    r_stg_valid <= 1'b0;
                    drop_ovf    <= 1'b1;
                end else if (w_data) begin
                    r_stg_data  <= in_data;
                    r_stg_valid <= 1'b1;
                    if (r_stg_valid & w_full) r_state <= DROP;
                end else if (w_end) begin
                    r_state     <= IDLE;
                    r_stg_valid <= 1'b0;
                    if (!w_commit) r_wr_ptr <= r_commit_ptr;
                    drop_crc    <= r_stg_valid & in_error;
                    drop_ovf    <= ~r_stg_valid | (~in_error & w_full);
                end
                DROP: if (w_start | w_end) begin
                    r_state     <= w_start ? RECV : IDLE;
                    r_wr_ptr    <= r_commit_ptr;
                    r_stg_valid <= 1'b0;
                    drop_ovf    <= 1'b1;
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rd_ptr  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (w_load) r_rd_ptr <= r_rd_ptr + 1'b1;
            out_valid <= w_load | (out_valid & ~out_ready);
        end
    end

`ifdef FRAME_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_good <= '0;
            stat_crc  <= '0;
            stat_ovf  <= '0;
        end else begin
            if (w_commit && stat_good != 16'hFFFF) stat_good <= stat_good + 1'b1;
            if (drop_crc && stat_crc != 16'hFFFF) stat_crc <= stat_crc + 1'b1;
            if (drop_ovf && stat_ovf != 16'hFFFF) stat_ovf <= stat_ovf + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_board_level_frame_buffer.sv
// tb_board_level_frame_buffer: directed frames through an 8-entry buffer, checked with immediate assertions.
module tb_board_level_frame_buffer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_frame_start = 1'b0, in_frame_end = 1'b0, in_valid = 1'b0, in_error = 1'b0;
    logic [7:0] in_data = '0;
    logic [7:0] out_data;
    logic       out_last, out_valid, drop_crc, drop_ovf;
    logic       out_ready = 1'b1;
    int         n_checks = 0, n_fail = 0;
    int         n_crc = 0, n_ovf = 0;
    logic [8:0] q[$];
    logic [8:0] held;
    logic       stable;

    board_level_frame_buffer #(.ADDR_WIDTH(3)) dut (
        .clk(clk), .rst(rst),
        .in_frame_start(in_frame_start), .in_frame_end(in_frame_end),
        .in_data(in_data), .in_valid(in_valid), .in_error(in_error),
        .out_data(out_data), .out_last(out_last), .out_valid(out_valid), .out_ready(out_ready),
        .drop_crc(drop_crc), .drop_ovf(drop_ovf)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (out_valid && out_ready) q.push_back({out_last, out_data});
        if (drop_crc) n_crc++;
        if (drop_ovf) n_ovf++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic ev(input logic s, input logic e, input logic [7:0] d, input logic err);
        @(posedge clk); #1;
        in_valid = 1'b1; in_frame_start = s; in_frame_end = e; in_data = d; in_error = err;
    endtask

    task automatic idle(input int n);
        @(posedge clk); #1;
        in_valid = 1'b0; in_frame_start = 1'b0; in_frame_end = 1'b0; in_error = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear();
        q.delete();
        n_crc = 0;
        n_ovf = 0;
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_last", out_last, 0);
        chk("rst_drops", {drop_crc, drop_ovf}, 0);
        rst = 1'b0;
        idle(2);

        clear();
        ev(1, 0, 0, 0); ev(0, 0, 8'h11, 0); ev(0, 0, 8'h22, 0); ev(0, 0, 8'h33, 0); ev(0, 0, 8'h44, 0); ev(0, 1, 0, 0);
        idle(12);
        chk("good_count", q.size(), 4);
        if (q.size() == 4) begin
            chk("good_b0", q[0], 9'h011);
            chk("good_b1", q[1], 9'h022);
            chk("good_b2", q[2], 9'h033);
            chk("good_b3", q[3], 9'h144);
        end
        chk("good_drops", n_crc + n_ovf, 0);

        clear();
        ev(1, 0, 0, 0); ev(0, 0, 8'h11, 0); ev(0, 0, 8'h22, 0); ev(0, 0, 8'h33, 0); ev(0, 0, 8'h44, 0); ev(0, 1, 0, 1);
        idle(8);
        chk("crc_no_output", q.size(), 0);
        chk("crc_pulses", n_crc, 1);
        chk("crc_valid_low", out_valid, 0);
        ev(1, 0, 0, 0); ev(0, 0, 8'hA5, 0); ev(0, 1, 0, 0);
        idle(8);
        chk("after_crc_count", q.size(), 1);
        if (q.size() == 1) chk("after_crc_b0", q[0], 9'h1A5);
        chk("after_crc_ovf", n_ovf, 0);

        clear();
        ev(1, 0, 0, 0);
        for (int i = 0; i < 10; i++) ev(0, 0, 8'(8'h80 + i), 0);
        ev(0, 1, 0, 0);
        idle(8);
        chk("ovf_pulses", n_ovf, 1);
        chk("ovf_no_output", q.size(), 0);
        ev(1, 0, 0, 0); ev(0, 0, 8'h31, 0); ev(0, 0, 8'h32, 0); ev(0, 0, 8'h33, 0); ev(0, 1, 0, 0);
        idle(8);
        chk("after_ovf_count", q.size(), 3);
        if (q.size() == 3) begin
            chk("after_ovf_b0", q[0], 9'h031);
            chk("after_ovf_b1", q[1], 9'h032);
            chk("after_ovf_b2", q[2], 9'h133);
        end

        clear();
        out_ready = 1'b0;
        ev(1, 0, 0, 0); ev(0, 0, 8'h41, 0); ev(0, 0, 8'h42, 0); ev(0, 1, 0, 0);
        ev(1, 0, 0, 0); ev(0, 0, 8'h51, 0); ev(0, 0, 8'h52, 0); ev(0, 0, 8'h53, 0); ev(0, 1, 0, 0);
        idle(2);
        chk("stall_valid", out_valid, 1);
        chk("stall_head", {out_last, out_data}, 9'h041);
        held = {out_last, out_data};
        stable = 1'b1;
        repeat (20) begin
            @(negedge clk);
            if (!out_valid || {out_last, out_data} !== held) stable = 1'b0;
        end
        chk("stall_stable", stable, 1);
        @(posedge clk); #1;
        out_ready = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("stall_count", q.size(), 5);
        if (q.size() == 5) begin
            chk("stall_b0", q[0], 9'h041);
            chk("stall_b1", q[1], 9'h142);
            chk("stall_b2", q[2], 9'h051);
            chk("stall_b3", q[3], 9'h052);
            chk("stall_b4", q[4], 9'h153);
        end

        clear();
        ev(1, 0, 0, 0); ev(0, 0, 8'h01, 0); ev(0, 0, 8'h02, 0); ev(1, 0, 0, 0); ev(0, 0, 8'h03, 0); ev(0, 1, 0, 0);
        idle(8);
        chk("abort_ovf", n_ovf, 1);
        chk("abort_count", q.size(), 1);
        if (q.size() == 1) chk("abort_b0", q[0], 9'h103);

        clear();
        ev(1, 0, 0, 0); ev(0, 0, 8'h61, 0); ev(0, 0, 8'h62, 0);
        @(posedge clk); #1;
        in_valid = 1'b0; in_frame_start = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_ptrs", {dut.r_wr_ptr, dut.r_commit_ptr, dut.r_rd_ptr}, 0);
        rst = 1'b0;
        ev(1, 0, 0, 0); ev(0, 0, 8'h77, 0); ev(0, 1, 0, 0);
        idle(8);
        chk("post_rst_count", q.size(), 1);
        if (q.size() == 1) chk("post_rst_b0", q[0], 9'h177);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/board_level_frame_buffer.md
Name: board_level_frame_buffer

Overview:
- Frame store downstream of the board-level data receiver. Consumes its byte stream: frame_start, data, frame_end, valid and the CRC error flag.
- Buffers each frame in on-chip RAM. A frame is released to the consumer only after its frame_end arrives with error=0.
- Frames with a CRC error, overflow, abort or zero length are discarded by rewinding the write pointer.
- Output is a valid/ready byte stream with a per-byte last flag.

Parameters:
- ADDR_WIDTH, 10, log2 of buffer depth; DEPTH = 2**ADDR_WIDTH entries of 9 bits ({last, data}).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- in_frame_start  in  1  frame start marker, qualified by in_valid
- in_frame_end  in  1  frame end marker, qualified by in_valid
- in_data  in  8  received byte, meaningful when in_valid=1 and both markers are 0
- in_valid  in  1  qualifier for markers and data
- in_error  in  1  CRC error flag, sampled only in the cycle in_valid & in_frame_end
- out_data  out  8  buffered byte
- out_last  out  1  marks the final byte of a frame
- out_valid  out  1  out_data/out_last valid
- out_ready  in  1  consumer accepts the byte when out_valid & out_ready
- drop_crc  out  1  one-cycle pulse: frame discarded for CRC error
- drop_ovf  out  1  one-cycle pulse: frame discarded for overflow, abort or zero length

Behaviour:
- Pointers: wr_ptr (speculative), commit_ptr and rd_ptr, each ADDR_WIDTH+1 bits, wrapping modulo 2*DEPTH.
  - full = (wr_ptr - rd_ptr) == DEPTH.
  - Committed data is present when commit_ptr != rd_ptr.
- Staging register: a byte is not written to RAM until the next in_valid event, because only that event decides whether it is the last byte.
  - Next event is a data byte: the staged byte is written with last=0 and the new byte is staged.
  - Next event is frame_end: the staged byte is written with last=1.
- Write FSM:
  - IDLE:
    - in_valid & frame_start -> RECV; wr_ptr <= commit_ptr; staging cleared.
    - Data and frame_end are ignored.
  - RECV, data byte: stage it; write any previously staged byte. If the write finds full, go to DROP and raise drop_ovf at frame end.
  - RECV, frame_end:
    - No byte staged: zero-length frame; drop_ovf pulses.
    - in_error=1: wr_ptr <= commit_ptr; drop_crc pulses.
    - Otherwise: write the staged byte with last=1, provided it is not full, then commit_ptr <= wr_ptr+1. If full, drop_ovf pulses.
    - All three cases go to IDLE.
  - RECV, frame_start: abort the current frame; wr_ptr <= commit_ptr; drop_ovf pulses; stay in RECV for the new frame.
  - DROP:
    - Data is ignored.
    - frame_end -> IDLE; wr_ptr <= commit_ptr; drop_ovf pulses.
    - frame_start -> rewind, drop_ovf pulses, go to RECV.
- Commit is atomic: commit_ptr updates in one cycle. The reader never observes part of an uncommitted frame.
- Read side:
  - The RAM has synchronous read with a one-entry show-ahead output register.
  - out_valid rises at most 2 cycles after commit_ptr advances.
  - One byte per cycle is sustained while out_ready=1.
  - out_data and out_last are held stable while out_valid=1 and out_ready=0.
- Simultaneous commit and read: both occur; pointers are independent.
- Reset: pointers 0, FSM IDLE, staging empty. Outputs reset to out_valid=0, out_data=0, out_last=0, drop_crc=0, drop_ovf=0.
  - A reset mid-frame discards all buffered and uncommitted data.

Optional Feature:
- FRAME_STATS_EN
  - Defined: adds outputs stat_good, stat_crc and stat_ovf, each 16 bits. They are saturating counters of committed frames, drop_crc pulses and drop_ovf pulses respectively. All reset to 0 and hold at 16'hFFFF once reached.
  - Undefined: the ports and logic are absent; behaviour is otherwise identical.

Decomposition:
- Shared package: FSM state encodings (IDLE, RECV, DROP) and the entry width constant (9).
- Sub-module board_level_frame_buffer_ram: simple dual-port RAM, 9-bit wide, DEPTH deep, one write port and one synchronous read port.

Test Plan:
- Good frame 0x11, 0x22, 0x33, 0x44 with error=0, out_ready=1: output 0x11, 0x22, 0x33, 0x44, out_last=1 only on 0x44; no drop pulses.
- Same frame with error=1: out_valid stays 0; drop_crc pulses once; a following good frame 0xA5 is output alone with last=1.
- ADDR_WIDTH=3, 10-byte frame: drop_ovf pulses at frame end; nothing is output. A subsequent 3-byte frame passes intact.
- Two good frames (2 and 3 bytes) with out_ready held 0 for 20 cycles, then 1: 5 bytes in order, last on bytes 2 and 5; data is stable while stalled.
- frame_start, 0x01, 0x02, then frame_start, 0x03, frame_end: drop_ovf pulses once; output is 0x03 with last=1.
- rst asserted after 2 bytes of a frame: out_valid=0 and all pointers 0; the next good frame 0x77 is output correctly.
